// File: rtl/access_ctrl_pkg.sv
// Shared definitions for the access-controlled register bank.
//   policy_state_e : policy FSM states (CFG after reset, LOCKED until reset)
//   addr_width()   : register index width, never narrower than one bit
//   reset_mask()   : one-hot allowed-ID mask granting only the admin ID
package access_ctrl_pkg;

  typedef enum logic {
    CFG    = 1'b0,
    LOCKED = 1'b1
  } policy_state_e;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough for any practical ID_W; callers truncate to their mask width.
  function automatic logic [255:0] reset_mask(input int admin_id);
    return 256'(1) << admin_id;
  endfunction

endpackage

// File: rtl/viol_logger.sv
// Violation counter and last-violation log.
//   clk, rst_n          : clock, asynchronous active-low reset
//   data_viol/id/addr   : denied data request this cycle and its requester/index
//   cfg_viol/id/addr    : rejected policy write this cycle and its requester/index
//   viol_cnt            : saturating count of violations
//   viol_id, viol_addr  : requester and index of the most recent violation
module viol_logger #(
  parameter int CNT_W = 8,
  parameter int ID_W  = 3,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_viol,
  input  logic [ID_W-1:0]  data_id,
  input  logic [AW-1:0]    data_addr,
  input  logic             cfg_viol,
  input  logic [ID_W-1:0]  cfg_id,
  input  logic [AW-1:0]    cfg_addr,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [ID_W-1:0]  viol_id,
  output logic [AW-1:0]    viol_addr
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic [1:0] inc_p0;

  assign inc_p0 = {1'b0, data_viol} + {1'b0, cfg_viol};

  // Stage p0 -> p1: count and log registered at the violating edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_cnt  <= '0;
      viol_id   <= '0;
      viol_addr <= '0;
    end else begin
      viol_cnt <= sat_add(viol_cnt, inc_p0);
      // Data-side information takes precedence when both sides violate.
      if (data_viol) begin
        viol_id   <= data_id;
        viol_addr <= data_addr;
      end else if (cfg_viol) begin
        viol_id   <= cfg_id;
        viol_addr <= cfg_addr;
      end
    end
  end

endmodule

// File: rtl/access_ctrl_reg_bank.sv
// Register bank whose per-register access is gated by an allowed-ID mask.
// The admin ID programs the masks and may lock the policy until reset.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   usr_id                          : requester ID for both req and cfg
//   req_valid/we/addr/wdata         : data request
//   rsp_valid/rdata/err             : response, one cycle after the request
//   cfg_valid/addr/mask/lock        : policy write (mask for one register)
//   locked                          : policy locked
//   viol_cnt/viol_id/viol_addr      : violation statistics
module access_ctrl_reg_bank
  import access_ctrl_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  parameter  int ID_W     = 3,
  parameter  int ADMIN_ID = 4,
  parameter  int CNT_W    = 8,
  localparam int AW       = addr_width(NUM_REGS),
  localparam int MW       = 2**ID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   usr_id,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              cfg_valid,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [MW-1:0]     cfg_mask,
  input  logic              cfg_lock,
  output logic              locked,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic [ID_W-1:0]   viol_id,
  output logic [AW-1:0]     viol_addr
);

  localparam logic [MW-1:0] RST_MASK = MW'(reset_mask(ADMIN_ID));

  logic [DATA_W-1:0] regs  [NUM_REGS];
  logic [MW-1:0]     masks [NUM_REGS];

  policy_state_e state_q, state_d;

  logic req_addr_ok_p0, cfg_addr_ok_p0;
  logic grant_p0, cfg_ok_p0;
  logic data_viol_p0, cfg_viol_p0;

  assign req_addr_ok_p0 = int'(req_addr) < NUM_REGS;
  assign cfg_addr_ok_p0 = int'(cfg_addr) < NUM_REGS;

  // Grant is purely combinational from this cycle's ID and the mask as it
  // stands before any same-edge policy write, so a coinciding cfg write to
  // the same register never affects the request it shares a cycle with.
  assign grant_p0 = req_addr_ok_p0 && masks[req_addr][usr_id];

  assign cfg_ok_p0 = cfg_valid && (state_q == CFG) &&
                     (usr_id == ID_W'(ADMIN_ID)) && cfg_addr_ok_p0;

  assign data_viol_p0 = req_valid && !grant_p0;
  assign cfg_viol_p0  = cfg_valid && !cfg_ok_p0;

  always_comb begin
    state_d = state_q;
    if (cfg_ok_p0 && cfg_lock) state_d = LOCKED;
  end

  // Stage p0 -> p1: policy state, masks, data registers, response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CFG;
    else        state_q <= state_d;
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) masks[i] <= RST_MASK;
    end else if (cfg_ok_p0) begin
      masks[cfg_addr] <= cfg_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (req_valid && req_we && grant_p0) begin
      regs[req_addr] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= req_valid;
      rsp_err   <= data_viol_p0;
      rsp_rdata <= (req_valid && !req_we && grant_p0) ? regs[req_addr] : '0;
    end
  end

  viol_logger #(
    .CNT_W (CNT_W),
    .ID_W  (ID_W),
    .AW    (AW)
  ) u_viol_logger (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_viol (data_viol_p0),
    .data_id   (usr_id),
    .data_addr (req_addr),
    .cfg_viol  (cfg_viol_p0),
    .cfg_id    (usr_id),
    .cfg_addr  (cfg_addr),
    .viol_cnt  (viol_cnt),
    .viol_id   (viol_id),
    .viol_addr (viol_addr)
  );

endmodule

// File: tb/tb_access_ctrl_reg_bank.sv
module tb_access_ctrl_reg_bank;

  localparam int DATA_W = 8;
  localparam int ID_W   = 3;
  localparam int AW     = 2;
  localparam int MW     = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ID_W-1:0]   usr_id = '0;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              cfg_valid = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [MW-1:0]     cfg_mask = '0;
  logic              cfg_lock = 1'b0;
  logic              locked;
  logic [CNT_W-1:0]  viol_cnt;
  logic [ID_W-1:0]   viol_id;
  logic [AW-1:0]     viol_addr;

  int tests = 0;
  int fails = 0;

  access_ctrl_reg_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .usr_id    (usr_id),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .cfg_valid (cfg_valid),
    .cfg_addr  (cfg_addr),
    .cfg_mask  (cfg_mask),
    .cfg_lock  (cfg_lock),
    .locked    (locked),
    .viol_cnt  (viol_cnt),
    .viol_id   (viol_id),
    .viol_addr (viol_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    cfg_valid = 1'b0;
    cfg_lock  = 1'b0;
  endtask

  task automatic req(input int id, input bit we, input int addr, input int data);
    usr_id    = ID_W'(id);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = DATA_W'(data);
  endtask

  task automatic cfg(input int addr, input int mask, input bit lock);
    cfg_valid = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_mask  = MW'(mask);
    cfg_lock  = lock;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %0b want 0", rsp_err); end
    tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL reset_rsp_rdata got %02h want 00", rsp_rdata); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %0b want 0", locked); end
    tests++; if (viol_cnt !== 8'd0) begin fails++; $display("FAIL reset_viol_cnt got %0d want 0", viol_cnt); end
    tests++; if (viol_id !== 3'd0 || viol_addr !== 2'd0) begin fails++; $display("FAIL reset_viol_log got id=%0d addr=%0d want 0/0", viol_id, viol_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_admin_write();
    req(4, 1'b1, 0, 'hA5);
    step();
    idle();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin fails++; $display("FAIL admin_wr_rsp got v=%0b e=%0b want 1/0", rsp_valid, rsp_err); end
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rsp_one_cycle got %0b want 0", rsp_valid); end
    req(4, 1'b0, 0, 0);
    step();
    idle();
    tests++; if (rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin fails++; $display("FAIL admin_rd got %02h e=%0b want a5/0", rsp_rdata, rsp_err); end
  endtask

  task automatic test_denied_write();
    req(3, 1'b1, 0, 'h11);
    step();
    idle();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin fails++; $display("FAIL denied_wr_rsp got v=%0b e=%0b want 1/1", rsp_valid, rsp_err); end
    tests++; if (viol_cnt !== 8'd1 || viol_id !== 3'd3 || viol_addr !== 2'd0) begin fails++; $display("FAIL denied_wr_viol got cnt=%0d id=%0d addr=%0d want 1/3/0", viol_cnt, viol_id, viol_addr); end
    req(3, 1'b0, 0, 0);
    step();
    tests++; if (rsp_rdata !== 8'h00 || rsp_err !== 1'b1 || viol_cnt !== 8'd2) begin fails++; $display("FAIL denied_rd got %02h e=%0b cnt=%0d want 00/1/2", rsp_rdata, rsp_err, viol_cnt); end
    req(4, 1'b0, 0, 0);
    step();
    idle();
    tests++; if (rsp_rdata !== 8'hA5) begin fails++; $display("FAIL denied_wr_unchanged got %02h want a5", rsp_rdata); end
  endtask

  task automatic test_no_stale_grant();
    req(4, 1'b1, 0, 'h5A);
    step();
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL stale_first_err got %0b want 0", rsp_err); end
    req(2, 1'b1, 0, 'hC3);
    step();
    tests++; if (rsp_err !== 1'b1 || viol_cnt !== 8'd3 || viol_id !== 3'd2) begin fails++; $display("FAIL stale_second got e=%0b cnt=%0d id=%0d want 1/3/2", rsp_err, viol_cnt, viol_id); end
    req(4, 1'b0, 0, 0);
    step();
    idle();
    tests++; if (rsp_rdata !== 8'h5A) begin fails++; $display("FAIL stale_data got %02h want 5a", rsp_rdata); end
  endtask

  task automatic test_same_cycle_viol();
    req(5, 1'b1, 2, 'h42);
    cfg(1, 'hFF, 1'b0);
    step();
    idle();
    tests++; if (viol_cnt !== 8'd5 || viol_id !== 3'd5 || viol_addr !== 2'd2) begin fails++; $display("FAIL dual_viol got cnt=%0d id=%0d addr=%0d want 5/5/2", viol_cnt, viol_id, viol_addr); end
    usr_id = 3'd6;
    cfg(3, 'hFF, 1'b0);
    step();
    idle();
    tests++; if (viol_cnt !== 8'd6 || viol_id !== 3'd6 || viol_addr !== 2'd3 || locked !== 1'b0) begin fails++; $display("FAIL cfg_viol got cnt=%0d id=%0d addr=%0d lk=%0b want 6/6/3/0", viol_cnt, viol_id, viol_addr, locked); end
  endtask

  task automatic test_old_mask();
    req(4, 1'b1, 2, 'h77);
    cfg(2, 'h04, 1'b0);
    step();
    idle();
    tests++; if (rsp_err !== 1'b0 || viol_cnt !== 8'd6) begin fails++; $display("FAIL old_mask_grant got e=%0b cnt=%0d want 0/6", rsp_err, viol_cnt); end
    req(4, 1'b1, 2, 'h99);
    step();
    tests++; if (rsp_err !== 1'b1 || viol_cnt !== 8'd7) begin fails++; $display("FAIL new_mask_deny got e=%0b cnt=%0d want 1/7", rsp_err, viol_cnt); end
    req(2, 1'b0, 2, 0);
    step();
    idle();
    tests++; if (rsp_rdata !== 8'h77 || rsp_err !== 1'b0) begin fails++; $display("FAIL new_mask_read got %02h e=%0b want 77/0", rsp_rdata, rsp_err); end
  endtask

  task automatic test_lock();
    usr_id = 3'd4;
    cfg(1, 'h08, 1'b1);
    step();
    idle();
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_set got %0b want 1", locked); end
    req(3, 1'b1, 1, 'h3C);
    step();
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL lock_id3_wr got e=%0b want 0", rsp_err); end
    req(3, 1'b0, 1, 0);
    step();
    idle();
    tests++; if (rsp_rdata !== 8'h3C) begin fails++; $display("FAIL lock_id3_rd got %02h want 3c", rsp_rdata); end
    usr_id = 3'd4;
    cfg(1, 'hFF, 1'b0);
    step();
    idle();
    tests++; if (viol_cnt !== 8'd8 || viol_id !== 3'd4 || viol_addr !== 2'd1 || locked !== 1'b1) begin fails++; $display("FAIL locked_cfg got cnt=%0d id=%0d addr=%0d lk=%0b want 8/4/1/1", viol_cnt, viol_id, viol_addr, locked); end
    req(4, 1'b1, 1, 'hEE);
    step();
    idle();
    tests++; if (rsp_err !== 1'b1 || viol_cnt !== 8'd9) begin fails++; $display("FAIL locked_mask_kept got e=%0b cnt=%0d want 1/9", rsp_err, viol_cnt); end
  endtask

  task automatic test_saturation();
    req(3, 1'b1, 0, 'h01);
    for (int i = 0; i < 300; i++) step();
    idle();
    step();
    tests++; if (viol_cnt !== 8'd255) begin fails++; $display("FAIL saturate got %0d want 255", viol_cnt); end
    req(5, 1'b1, 2, 'h01);
    cfg(0, 'h00, 1'b0);
    step();
    idle();
    tests++; if (viol_cnt !== 8'd255 || viol_id !== 3'd5) begin fails++; $display("FAIL saturate_hold got cnt=%0d id=%0d want 255/5", viol_cnt, viol_id); end
  endtask

  task automatic test_reset_midop();
    req(3, 1'b1, 0, 'h01);
    step();
    req(4, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || locked !== 1'b0 || viol_cnt !== 8'd0) begin fails++; $display("FAIL midop_async got v=%0b lk=%0b cnt=%0d want 0/0/0", rsp_valid, locked, viol_cnt); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL midop_no_rsp got %0b want 0", rsp_valid); end
    req(4, 1'b0, 0, 0);
    step();
    tests++; if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin fails++; $display("FAIL midop_regs_cleared got %02h e=%0b want 00/0", rsp_rdata, rsp_err); end
    req(3, 1'b1, 1, 'h12);
    step();
    idle();
    tests++; if (rsp_err !== 1'b1) begin fails++; $display("FAIL midop_mask_reset got e=%0b want 1", rsp_err); end
  endtask

  initial begin
    test_reset();
    test_admin_write();
    test_denied_write();
    test_no_stale_grant();
    test_same_cycle_viol();
    test_old_mask();
    test_lock();
    test_saturation();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/access_ctrl_reg_bank.md
ACCESS_CTRL_REG_BANK -- requirements
Module: access_ctrl_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each data register.
REQ-002 SHALL have parameter NUM_REGS, default 4, number of protected registers; AW = max(1, clog2(NUM_REGS)).
REQ-003 SHALL have parameter ID_W, default 3, width of the user ID; mask width MW = 2**ID_W.
REQ-004 SHALL have parameter ADMIN_ID, default 4, the only ID permitted to program policy.
REQ-005 SHALL have parameter CNT_W, default 8, violation counter width.
REQ-006 SHALL have ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- usr_id  in  ID_W  requester ID, same cycle as req/cfg
- req_valid  in  1  data request strobe
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  register index
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  request denied
- cfg_valid  in  1  policy-write strobe
- cfg_addr  in  AW  register whose mask is written
- cfg_mask  in  MW  new allowed-ID mask, bit i = ID i allowed
- cfg_lock  in  1  lock policy after this write
- locked  out  1  policy locked
- viol_cnt  out  CNT_W  saturating violation count
- viol_id  out  ID_W  ID of latest violation
- viol_addr  out  AW  address of latest violation

Function
REQ-007 SHALL compute grant = mask[req_addr][usr_id] combinationally from the current-cycle usr_id and current mask, never from a grant registered in an earlier cycle.
REQ-008 SHALL, on a granted write, update reg[req_addr] at that clock edge.
REQ-009 SHALL, on a denied write, leave every register unchanged.
REQ-010 SHALL assert rsp_valid for exactly one cycle, one cycle after each req_valid; rsp_err = !grant.
REQ-011 SHALL drive rsp_rdata on a granted read with reg[req_addr] as it was at the request edge; otherwise 0.
REQ-012 SHALL treat req_addr >= NUM_REGS as denied.
REQ-013 SHALL implement policy FSM states CFG (after reset) and LOCKED; locked = (state == LOCKED).
REQ-014 SHALL, in CFG, on cfg_valid with usr_id == ADMIN_ID and cfg_addr < NUM_REGS, write mask[cfg_addr] = cfg_mask.
REQ-015 SHALL transition CFG -> LOCKED when an accepted cfg write has cfg_lock = 1, with that mask write applied.
REQ-016 SHALL leave LOCKED only via reset.
REQ-017 SHALL ignore and count as a violation: cfg_valid in LOCKED, cfg_valid from a non-admin ID, and cfg_addr out of range.
REQ-018 SHALL apply the old mask to a data request when that request coincides with a cfg write to the same address.
REQ-019 SHALL increment viol_cnt by the number of violations in the cycle (0, 1 or 2), saturating at 2**CNT_W-1.
REQ-020 SHALL update viol_id/viol_addr on every violation; when a data violation and a cfg violation occur in the same cycle, the data-request values win.

Reset
REQ-021 SHALL asynchronously set state = CFG, all registers = 0, and every mask = (1 << ADMIN_ID).
REQ-022 SHALL reset rsp_valid, rsp_err, rsp_rdata, viol_cnt, viol_id and viol_addr to 0, and locked to 0.
REQ-023 SHALL discard any response pending when reset asserts mid-operation; no rsp_valid SHALL appear in the first cycle after release.

Structure
REQ-024 SHALL place the FSM state enum (CFG, LOCKED) and the reset-mask helper function in package access_ctrl_pkg.
REQ-025 SHALL implement violation counting and logging in sub-module viol_logger (parameters CNT_W, ID_W, AW).

Verification
REQ-026 After reset, usr_id=4 writes 0xA5 to addr 0 -> next cycle rsp_valid=1, rsp_err=0; a read by ID 4 returns 0xA5.
REQ-027 usr_id=3 writes 0x11 to addr 0 under the reset mask -> rsp_err=1, reg unchanged, viol_cnt=1, viol_id=3, viol_addr=0.
REQ-028 ID 4 programs mask[1]=0x08 with cfg_lock=1 -> locked=1; ID 3 write of 0x3C to addr 1 succeeds; a later cfg write of mask[1]=0xFF by ID 4 is ignored and viol_cnt increments.
REQ-029 usr_id toggles 4 -> 2 on consecutive write cycles to addr 0 -> only the first write lands (no stale grant).
REQ-030 Same cycle: cfg write by ID 5 plus denied data write by ID 5 to addr 2 -> viol_cnt += 2, viol_id=5, viol_addr=2; 300 violations saturate viol_cnt at 255.
